// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI pins / RAM port and the spi_slave_if front end.
// Optional build macro: SPI_SLV_FRAME_ERR_EN adds the frame_err signal.
interface spi_slave_if_if #(
   parameter int ADDR_SIZE = 8
);
   logic                   MOSI;
   logic                   SS_n;
   logic                   MISO;
   logic [ADDR_SIZE+1:0]   rx_data;
   logic                   rx_valid;
   logic [ADDR_SIZE-1:0]   tx_data;
   logic                   tx_valid;
`ifdef SPI_SLV_FRAME_ERR_EN
   logic                   frame_err;

   // Slave side: the front end itself
   modport slave (
      input  MOSI, SS_n, tx_data, tx_valid,
      output MISO, rx_data, rx_valid, frame_err
   );

   // Master side: SPI master plus RAM, as seen by whoever drives the front end
   modport master (
      output MOSI, SS_n, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid, frame_err
   );
`else
   // Slave side: the front end itself
   modport slave (
      input  MOSI, SS_n, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );

   // Master side: SPI master plus RAM, as seen by whoever drives the front end
   modport master (
      output MOSI, SS_n, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );
`endif
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end for the SPI-RAM subsystem.
// Deserialises SS_n-framed MOSI words (opcode + address/data) into rx_data,
// and shifts the RAM read byte back out on MISO. clk doubles as SCLK.
// Optional build macro: SPI_SLV_FRAME_ERR_EN adds a frame_err pulse output.
module spi_slave_if #(
   parameter int ADDR_SIZE = 8
) (
   input  logic           clk,
   input  logic           rst,
   spi_slave_if_if.slave  bus
);

   localparam int W     = ADDR_SIZE + 2;
   localparam int CNT_W = $clog2(W + 1);
   localparam int TX_W  = $clog2(ADDR_SIZE + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t                 state;
   logic [W-2:0]           shift_reg;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   word_done;
   logic                   rd_addr_done;
   logic                   tx_wait;
   logic                   tx_busy;
   logic [ADDR_SIZE-1:0]   tx_shift;
   logic [TX_W-1:0]        tx_cnt;
   logic [W-1:0]           rx_data_r;
   logic                   rx_valid_r;
   logic                   miso_r;
   logic [W-1:0]           captured;

   // The word as it will look once the current MOSI bit is shifted in
   assign captured = {shift_reg, bus.MOSI};

   assign bus.rx_data  = rx_data_r;
   assign bus.rx_valid = rx_valid_r;
   assign bus.MISO     = miso_r;

`ifdef SPI_SLV_FRAME_ERR_EN
   logic frame_err_r;
   assign bus.frame_err = frame_err_r;
`endif

   // Frame FSM: receive the command word, strobe it out, and serve read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         word_done    <= 1'b0;
         rd_addr_done <= 1'b0;
         tx_wait      <= 1'b0;
         tx_busy      <= 1'b0;
         tx_shift     <= '0;
         tx_cnt       <= '0;
         rx_data_r    <= '0;
         rx_valid_r   <= 1'b0;
         miso_r       <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
         frame_err_r  <= 1'b0;
`endif
      end else begin
         rx_valid_r <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
         frame_err_r <= 1'b0;
`endif
         if (state != IDLE && bus.SS_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            tx_wait   <= 1'b0;
            tx_busy   <= 1'b0;
            miso_r    <= 1'b0;
`ifdef SPI_SLV_FRAME_ERR_EN
            frame_err_r <= ~word_done;
`endif
         end else begin
            case (state)
               IDLE: begin
                  shift_reg <= '0;
                  bit_cnt   <= '0;
                  word_done <= 1'b0;
                  tx_wait   <= 1'b0;
                  tx_busy   <= 1'b0;
                  miso_r    <= 1'b0;
                  if (!bus.SS_n)
                     state <= CHK_CMD;
               end

               CHK_CMD: begin
                  shift_reg <= captured[W-2:0];
                  bit_cnt   <= CNT_W'(1);
                  if (!bus.MOSI)
                     state <= WRITE;
                  else if (rd_addr_done)
                     state <= READ_DATA;
                  else
                     state <= READ_ADD;
               end

               WRITE, READ_ADD, READ_DATA: begin
                  if (!word_done) begin
                     shift_reg <= captured[W-2:0];
                     if (bit_cnt == CNT_W'(W - 1)) begin
                        bit_cnt    <= CNT_W'(W);
                        word_done  <= 1'b1;
                        rx_data_r  <= captured;
                        rx_valid_r <= 1'b1;
                        if (state == READ_ADD)
                           rd_addr_done <= 1'b1;
                        if (state == READ_DATA) begin
                           rd_addr_done <= 1'b0;
                           tx_wait      <= 1'b1;
                        end
`ifdef SPI_SLV_FRAME_ERR_EN
                        case (state)
                           WRITE:     frame_err_r <= captured[W-1];
                           READ_ADD:  frame_err_r <= (captured[W-1:W-2] != 2'b10);
                           default:   frame_err_r <= (captured[W-1:W-2] != 2'b11);
                        endcase
`endif
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end else if (state == READ_DATA && tx_wait) begin
                     if (bus.tx_valid) begin
                        miso_r   <= bus.tx_data[ADDR_SIZE-1];
                        tx_shift <= bus.tx_data << 1;
                        tx_cnt   <= TX_W'(ADDR_SIZE - 1);
                        tx_wait  <= 1'b0;
                        tx_busy  <= 1'b1;
                     end
                  end else if (state == READ_DATA && tx_busy) begin
                     if (tx_cnt != '0) begin
                        miso_r   <= tx_shift[ADDR_SIZE-1];
                        tx_shift <= tx_shift << 1;
                        tx_cnt   <= tx_cnt - TX_W'(1);
                     end else begin
                        miso_r  <= 1'b0;
                        tx_busy <= 1'b0;
                     end
                  end else begin
                     miso_r <= 1'b0;
                  end
               end

               default: begin
                  state  <= IDLE;
                  miso_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if.
// Build with SPI_SLV_FRAME_ERR_EN defined to also exercise frame_err.
module tb_spi_slave_if;

   localparam int ADDR_SIZE = 8;

   logic clk = 1'b0;
   logic rst;

   spi_slave_if_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

   spi_slave_if #(.ADDR_SIZE(ADDR_SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc, strobes, strobeCyc, misoOnes, errPulses;
   logic [9:0] lastData;
   logic [7:0] misoBits;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp)
         passes++;
      else
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock, then observe outputs 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rx_valid === 1'b1) begin
         strobes++;
         strobeCyc = cyc;
         lastData  = bus.rx_data;
      end
      if (bus.MISO === 1'b1)
         misoOnes++;
`ifdef SPI_SLV_FRAME_ERR_EN
      if (bus.frame_err === 1'b1)
         errPulses++;
`endif
   endtask

   task automatic clearMonitor();
      cyc       = 0;
      strobes   = 0;
      strobeCyc = -1;
      misoOnes  = 0;
      errPulses = 0;
   endtask

   // Drop SS_n (cycle 0), then send the first nbits of word MSB first
   task automatic applyStimulus(input logic [9:0] word, input int nbits);
      clearMonitor();
      bus.SS_n = 1'b0;
      bus.MOSI = 1'b0;
      step();
      for (int i = 0; i < nbits; i++) begin
         bus.MOSI = word[9-i];
         step();
      end
   endtask

   // Release SS_n for one cycle
   task automatic endFrame();
      bus.SS_n = 1'b1;
      bus.MOSI = 1'b0;
      step();
   endtask

   initial begin
      rst          = 1'b1;
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'b0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      clearMonitor();
      repeat (3) step();
      checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
      checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h000);
      checkOutput("reset_miso", 32'(bus.MISO), 32'd0);
      checkOutput("reset_state", 32'(dut.state), 32'd0);
      checkOutput("reset_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
      rst = 1'b0;
      step();

      // Write address frame: one strobe in cycle 11, then parked in WRITE
      applyStimulus(10'h03C, 10);
      checkOutput("wa_strobes", 32'(strobes), 32'd1);
      checkOutput("wa_cycle", 32'(strobeCyc), 32'd11);
      checkOutput("wa_data", 32'(lastData), 32'h03C);
      bus.MOSI = 1'b1;
      repeat (3) step();
      checkOutput("wa_no_restrobe", 32'(strobes), 32'd1);
      checkOutput("wa_state_write", 32'(dut.state), 32'd2);
      endFrame();
      checkOutput("wa_idle", 32'(dut.state), 32'd0);

      // Write data frame: MISO never rises, rx_data holds afterwards
      applyStimulus(10'h1A5, 10);
      endFrame();
      checkOutput("wd_strobes", 32'(strobes), 32'd1);
      checkOutput("wd_data", 32'(lastData), 32'h1A5);
      checkOutput("wd_miso_quiet", 32'(misoOnes), 32'd0);
      step();
      checkOutput("wd_rx_hold", 32'(bus.rx_data), 32'h1A5);

      // Read address then read data frame with an A5 reply
      applyStimulus(10'h23C, 10);
      checkOutput("ra_data", 32'(lastData), 32'h23C);
      checkOutput("ra_strobes", 32'(strobes), 32'd1);
      checkOutput("ra_addr_done", 32'(dut.rd_addr_done), 32'd1);
      endFrame();
      applyStimulus(10'h3FF, 10);
      checkOutput("rd_data", 32'(lastData), 32'h3FF);
      checkOutput("rd_cycle", 32'(strobeCyc), 32'd11);
      checkOutput("rd_addr_cleared", 32'(dut.rd_addr_done), 32'd0);
      checkOutput("rd_state", 32'(dut.state), 32'd4);
      step();
      checkOutput("rd_miso_idle_wait", 32'(bus.MISO), 32'd0);
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      for (int k = 0; k < 8; k++) begin
         misoBits[7-k] = bus.MISO;
         step();
      end
      checkOutput("rd_miso_byte", 32'(misoBits), 32'hA5);
      checkOutput("rd_miso_after", 32'(bus.MISO), 32'd0);
      misoOnes = 0;
      bus.tx_data  = 8'hFF;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      repeat (3) step();
      checkOutput("rd_late_tx_ignored", 32'(misoOnes), 32'd0);
      endFrame();

      // Abort after 5 bits, then a full frame after a single idle cycle
      applyStimulus(10'h155, 5);
      endFrame();
      checkOutput("ab_no_strobe", 32'(strobes), 32'd0);
      checkOutput("ab_idle", 32'(dut.state), 32'd0);
`ifdef SPI_SLV_FRAME_ERR_EN
      checkOutput("ab_frame_err", 32'(errPulses), 32'd1);
`endif
      applyStimulus(10'h155, 10);
      checkOutput("ab_full_strobes", 32'(strobes), 32'd1);
      checkOutput("ab_full_data", 32'(lastData), 32'h155);
      checkOutput("ab_full_cycle", 32'(strobeCyc), 32'd11);
      endFrame();

      // SS_n rises together with the last bit of a read-address frame
      applyStimulus(10'h2AA, 9);
      bus.MOSI = 1'b0;
      bus.SS_n = 1'b1;
      step();
      step();
      checkOutput("lastbit_abort_strobes", 32'(strobes), 32'd0);
      checkOutput("lastbit_abort_addr_done", 32'(dut.rd_addr_done), 32'd0);
      checkOutput("lastbit_abort_rx_hold", 32'(bus.rx_data), 32'h155);

      // Reset while the read byte is shifting out
      applyStimulus(10'h200, 10);
      endFrame();
      checkOutput("rr_addr_done", 32'(dut.rd_addr_done), 32'd1);
      applyStimulus(10'h300, 10);
      step();
      bus.tx_data  = 8'hFF;
      bus.tx_valid = 1'b1;
      step();
      bus.tx_valid = 1'b0;
      checkOutput("rr_miso_shifting", 32'(bus.MISO), 32'd1);
      step();
      rst = 1'b1;
      step();
      checkOutput("rr_miso", 32'(bus.MISO), 32'd0);
      checkOutput("rr_rx_valid", 32'(bus.rx_valid), 32'd0);
      checkOutput("rr_state", 32'(dut.state), 32'd0);
      checkOutput("rr_addr_done_clr", 32'(dut.rd_addr_done), 32'd0);
      checkOutput("rr_rx_data", 32'(bus.rx_data), 32'h000);
      bus.SS_n = 1'b1;
      rst = 1'b0;
      step();

`ifdef SPI_SLV_FRAME_ERR_EN
      // Frame-error cases: short abort, clean write, wrong read prefix
      applyStimulus(10'h000, 3);
      endFrame();
      checkOutput("fe_short_abort", 32'(errPulses), 32'd1);
      applyStimulus(10'h0F0, 10);
      endFrame();
      checkOutput("fe_clean_write", 32'(errPulses), 32'd0);
      applyStimulus(10'h312, 10);
      checkOutput("fe_prefix_err", 32'(errPulses), 32'd1);
      checkOutput("fe_prefix_strobe", 32'(strobes), 32'd1);
      checkOutput("fe_prefix_data", 32'(lastData), 32'h312);
      endFrame();
`endif

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
